// File: rtl/sprite_layer_compositor.sv
`default_nettype none
// ============================================================================
// sprite_layer_compositor -- RGB332 sprite priority mux plus per-frame player
// collision reporting with cooldown. Option macro: SPRITE_COLLISION_OVERLAY_EN
// Revision: 1.0
// ============================================================================
module sprite_layer_compositor #(
  parameter int         NUM_LAYERS      = 4,
  parameter logic [7:0] MASK_VALUE      = 8'h62,
  parameter logic [7:0] BG_COLOR        = 8'h00,
  parameter int         COOLDOWN_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         frame_start,
  input  logic                         pixel_valid,
  input  logic [NUM_LAYERS-1:0][7:0]   layer_color,
  output logic [7:0]                   rgb_out,
  output logic                         rgb_valid,
  output logic [NUM_LAYERS-1:0]        collision_vec,
  output logic                         collision_pulse
);

  localparam logic [7:0] CD_RELOAD = 8'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  logic [NUM_LAYERS-1:0][7:0] s1_color;
  logic [NUM_LAYERS-1:0]      s1_opaque;
  logic                       s1_valid;
  logic [NUM_LAYERS-1:0]      opaque;
  logic [NUM_LAYERS-1:0]      hit;
  logic [NUM_LAYERS-1:0]      cd_idle;
  logic [NUM_LAYERS-1:0]      rep;
  logic [NUM_LAYERS-1:0]      acc;
  logic [7:0]                 cd [1:NUM_LAYERS-1];
  logic [7:0]                 prio_color;
  logic [7:0]                 next_rgb;
  state_t                     state;

  generate
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
      assign opaque[k] = (layer_color[k] != MASK_VALUE);
      if (k == 0) begin : g_player
        // The player never collides with itself and has no cooldown.
        assign hit[k]     = 1'b0;
        assign cd_idle[k] = 1'b0;
      end else begin : g_other
        assign hit[k]     = s1_valid & s1_opaque[0] & s1_opaque[k];
        assign cd_idle[k] = (cd[k] == 8'd0);
      end
    end
  endgenerate

  assign rep = acc & cd_idle;

  // Scan from the lowest priority upward so the lowest opaque index wins.
  always_comb begin
    prio_color = BG_COLOR;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (s1_opaque[k]) prio_color = s1_color[k];
    end
  end

`ifdef SPRITE_COLLISION_OVERLAY_EN
  localparam logic [7:0] OVERLAY_COLOR = 8'hE0;

  always_comb begin
    next_rgb = 8'h00;
    if (s1_valid) next_rgb = (|hit) ? OVERLAY_COLOR : prio_color;
  end
`else
  assign next_rgb = s1_valid ? prio_color : 8'h00;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_color  <= '0;
      s1_opaque <= '0;
      s1_valid  <= 1'b0;
      rgb_out   <= 8'h00;
      rgb_valid <= 1'b0;
    end else begin
      s1_color  <= layer_color;
      s1_opaque <= opaque;
      s1_valid  <= pixel_valid;
      rgb_out   <= next_rgb;
      rgb_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      acc             <= '0;
      collision_vec   <= '0;
      collision_pulse <= 1'b0;
      for (int k = 1; k < NUM_LAYERS; k++) cd[k] <= 8'd0;
    end else begin
      collision_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) state <= ACCUM;
        end
        ACCUM: begin
          // The hit in flight on the closing edge still belongs to this frame.
          acc <= acc | hit;
          if (frame_start) state <= REPORT;
        end
        REPORT: begin
          collision_vec   <= rep;
          collision_pulse <= |rep;
          acc             <= hit;
          for (int k = 1; k < NUM_LAYERS; k++) begin
            if (rep[k])              cd[k] <= CD_RELOAD;
            else if (cd[k] != 8'd0)  cd[k] <= cd[k] - 8'd1;
          end
          state <= ACCUM;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_compositor.sv
`default_nettype none
// tb_sprite_layer_compositor -- directed and random stimulus against a
// frame-window reference model of the compositor.
module tb_sprite_layer_compositor;

  localparam int         NL   = 4;
  localparam int         CDF  = 3;
  localparam logic [7:0] MASK = 8'h62;
  localparam int         HMAX = 8192;

  typedef logic [NL-1:0][7:0] colors_t;

  logic          clk = 1'b0;
  logic          resetN = 1'b1;
  logic          frame_start = 1'b0;
  logic          pixel_valid = 1'b0;
  colors_t       layer_color;
  logic [7:0]    rgb_out;
  logic          rgb_valid;
  logic [NL-1:0] collision_vec;
  logic          collision_pulse;

  sprite_layer_compositor #(
    .NUM_LAYERS(NL), .MASK_VALUE(MASK), .BG_COLOR(8'h00), .COOLDOWN_FRAMES(CDF)
  ) dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .layer_color(layer_color), .rgb_out(rgb_out), .rgb_valid(rgb_valid),
    .collision_vec(collision_vec), .collision_pulse(collision_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-edge input history since the last reset.
  colors_t       h_col [HMAX];
  logic          h_val [HMAX];
  logic          h_fs  [HMAX];
  logic [NL-1:0] h_hit [HMAX];
  int            n;
  bit            started;
  int            win_start;
  int            rep_edge;
  int            rep_idx;
  int            last_rep [NL];
  logic [NL-1:0] exp_vec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic colors_t mk(input logic [7:0] l0, l1, l2, l3);
    colors_t c;
    c[0] = l0; c[1] = l1; c[2] = l2; c[3] = l3;
    return c;
  endfunction

  function automatic colors_t rand_colors();
    colors_t c;
    for (int k = 0; k < NL; k++)
      c[k] = ($urandom_range(0, 1) == 0) ? MASK : 8'($urandom_range(0, 255));
    return c;
  endfunction

  function automatic logic [NL-1:0] hits_of(input logic v, input colors_t c);
    logic [NL-1:0] h = '0;
    for (int k = 1; k < NL; k++) h[k] = v && (c[0] != MASK) && (c[k] != MASK);
    return h;
  endfunction

  function automatic logic [7:0] ref_pixel(input logic v, input colors_t c);
    if (!v) return 8'h00;
`ifdef SPRITE_COLLISION_OVERLAY_EN
    if (hits_of(v, c) != '0) return 8'hE0;
`endif
    for (int k = 0; k < NL; k++) if (c[k] != MASK) return c[k];
    return 8'h00;
  endfunction

  task automatic model_clear();
    n = 0; started = 0; win_start = 0; rep_edge = -10; rep_idx = 0; exp_vec = '0;
    for (int k = 0; k < NL; k++) last_rep[k] = 0;
  endtask

  // One clock: drive inputs, let the edge happen, compare against the model.
  task automatic step(input logic fs, input logic v, input colors_t c);
    logic [7:0]    exp_rgb;
    logic          exp_rv;
    logic          exp_pulse;
    logic [NL-1:0] w;
    logic [NL-1:0] vec;
    @(negedge clk);
    frame_start = fs; pixel_valid = v; layer_color = c;
    h_col[n] = c; h_val[n] = v; h_fs[n] = fs; h_hit[n] = hits_of(v, c);
    @(posedge clk);
    #1;
    exp_rgb = 8'h00; exp_rv = 1'b0; exp_pulse = 1'b0;
    if (n >= 1) begin
      exp_rgb = ref_pixel(h_val[n-1], h_col[n-1]);
      exp_rv  = h_val[n-1];
      if (h_fs[n-1]) begin
        if (!started) begin
          started = 1; win_start = n - 1;
        end else if (n - 1 != rep_edge + 1) begin
          // Frame window: pixels sampled from the previous boundary edge up to
          // one edge before this boundary.
          w = '0;
          for (int i = win_start; i <= n - 2; i++) w |= h_hit[i];
          rep_idx++;
          vec = '0;
          for (int k = 1; k < NL; k++)
            if (w[k] && (last_rep[k] == 0 || rep_idx - last_rep[k] > CDF)) begin
              vec[k] = 1'b1; last_rep[k] = rep_idx;
            end
          exp_vec = vec; exp_pulse = |vec; win_start = n - 1; rep_edge = n - 1;
        end
      end
    end
    check("rgb_out", 32'(rgb_out), 32'(exp_rgb));
    check("rgb_valid", 32'(rgb_valid), 32'(exp_rv));
    check("collision_vec", 32'(collision_vec), 32'(exp_vec));
    check("collision_pulse", 32'(collision_pulse), 32'(exp_pulse));
    n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    frame_start = 1'b0; pixel_valid = 1'b0; layer_color = mk(MASK, MASK, MASK, MASK);
    resetN = 1'b0;
    #1;
    check("rst_rgb_out", 32'(rgb_out), 32'h0);
    check("rst_rgb_valid", 32'(rgb_valid), 32'h0);
    check("rst_collision_vec", 32'(collision_vec), 32'h0);
    check("rst_collision_pulse", 32'(collision_pulse), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    model_clear();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, mk(MASK, MASK, MASK, MASK));
  endtask

  initial begin
    layer_color = mk(MASK, MASK, MASK, MASK);
    model_clear();
    do_reset();

    // Priority, transparency and valid gating.
    step(1'b1, 1'b0, mk(MASK, MASK, MASK, MASK));
    step(1'b0, 1'b1, mk(MASK, 8'h1F, 8'hE4, MASK));
    step(1'b0, 1'b1, mk(MASK, MASK, MASK, MASK));
    step(1'b0, 1'b0, mk(8'hFF, MASK, MASK, MASK));
    step(1'b0, 1'b1, mk(8'h63, 8'h61, MASK, MASK));
    step(1'b0, 1'b1, mk(8'hFF, MASK, MASK, 8'h0C));
    idle(3);

    // Collision with layer 2 reported at the next boundary (plus a stray
    // frame_start during the report cycle).
    step(1'b1, 1'b0, mk(MASK, MASK, MASK, MASK));
    step(1'b0, 1'b1, mk(8'hFF, MASK, 8'hE4, MASK));
    idle(4);
    step(1'b1, 1'b0, mk(MASK, MASK, MASK, MASK));
    step(1'b1, 1'b0, mk(MASK, MASK, MASK, MASK));
    idle(4);

    // Cooldown: overlap with layer 1 every frame, hit placed one cycle
    // before the boundary.
    do_reset();
    step(1'b1, 1'b0, mk(MASK, MASK, MASK, MASK));
    for (int f = 0; f < 7; f++) begin
      idle(3);
      step(1'b0, 1'b1, mk(8'h10, 8'h20, MASK, MASK));
      step(1'b1, 1'b0, mk(MASK, MASK, MASK, MASK));
    end
    idle(3);

    // Reset mid-frame after a hit; the following report must be clean.
    step(1'b0, 1'b1, mk(8'hFF, MASK, MASK, 8'h33));
    step(1'b0, 1'b1, mk(8'hFF, 8'h44, MASK, MASK));
    do_reset();
    step(1'b1, 1'b0, mk(MASK, MASK, MASK, MASK));
    idle(5);
    step(1'b1, 1'b0, mk(MASK, MASK, MASK, MASK));
    idle(3);

    // Random frames.
    do_reset();
    idle(2);
    for (int f = 0; f < 200; f++) begin
      int len;
      len = $urandom_range(3, 14);
      step(1'b1, ($urandom_range(0, 4) != 0), rand_colors());
      for (int i = 1; i < len; i++)
        step((i == 1) && ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0), rand_colors());
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_layer_compositor.md
Name: sprite_layer_compositor

Overview:
- Downstream of the per-object sprite generators (player car, AI cars, bonus car). Each generator emits an 8-bit RGB332 colour per pixel, with 8'h62 meaning transparent.
- Per pixel, selects the highest-priority opaque layer and registers it toward the VGA output stage.
- Per frame, detects pixel-overlap collisions between the player layer and every other layer.
- Reports collisions once per frame, with a per-layer cooldown so a single crash is not reported every frame.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 = player, 1..NUM_LAYERS-1 = other objects; lower index = higher draw priority.
- MASK_VALUE, 8'h62, transparent colour code.
- BG_COLOR, 8'h00, colour driven when every layer is transparent.
- COOLDOWN_FRAMES, 30, frames a layer's collision report is suppressed after it is reported; range 1..255.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of each frame
- pixel_valid  in  1  high during the active display area
- layer_color  in  NUM_LAYERS x 8  per-layer pixel colour for the current pixel
- rgb_out  out  8  composited pixel colour
- rgb_valid  out  1  pixel_valid delayed to align with rgb_out
- collision_vec  out  NUM_LAYERS  collisions reported for the previous frame; bit 0 always 0
- collision_pulse  out  1  one-cycle pulse when collision_vec is updated with a nonzero value

Behaviour:
- Reset: clk, asynchronous active-low resetN; every output and every internal register clears to 0. That covers rgb_out=0, rgb_valid=0, collision_vec=0, collision_pulse=0, accumulators=0, cooldown counters=0, FSM=IDLE.
- Pipeline stage 1 registers:
  - layer_color;
  - opaque bits, opaque[k] = (layer_color[k] != MASK_VALUE);
  - pixel_valid.
- Pipeline stage 2 drives:
  - rgb_out = colour of the lowest-index opaque layer, else BG_COLOR;
  - rgb_out = 8'h00 when the stage-1 valid is low;
  - rgb_valid = stage-1 valid.
- Latency: exactly 2 clk from inputs to rgb_out/rgb_valid; full throughput, no stalls.
- Hit detection uses stage-1 data: hit[k] = valid & opaque[0] & opaque[k], for k >= 1. Hits OR into the accumulator acc[k] while in ACCUM.
- FSM:
  - IDLE: wait for the first frame_start, then go to ACCUM.
  - ACCUM: accumulate. On frame_start, go to REPORT; acc is sampled that same cycle, including any hit in flight in stage 1.
  - REPORT (one cycle), for each k >= 1:
    - rep[k] = acc[k] & (cd[k] == 0);
    - collision_vec <= rep;
    - if rep[k], cd[k] <= COOLDOWN_FRAMES; else if cd[k] != 0, cd[k] <= cd[k] - 1;
    - acc cleared;
    - collision_pulse <= |rep;
    - next state ACCUM.
- Hits arriving during the REPORT cycle count toward the new frame; they are ORed into the freshly cleared acc.
- collision_vec holds its value for the whole frame until the next REPORT.
- A second frame_start while in REPORT is ignored; a frame_start in IDLE only moves the FSM to ACCUM.
- The cooldown counter decrements once per REPORT, saturating at 0.
- Reset mid-frame discards the accumulators and the pipeline contents immediately.
- Opaque is a strict inequality against MASK_VALUE. Layer 0 never reports a collision with itself.

Optional Feature:
- Macro: SPRITE_COLLISION_OVERLAY_EN.
- Defined: in stage 2, any pixel with hit[k] for some k >= 1 drives rgb_out = 8'hE0 (red) instead of the priority colour. Latency is unchanged.
- Not defined: no overlay logic is present; rgb_out is the pure priority selection.

Test Plan:
- Priority and latency:
  - Stimulus: layer_color = {8'h62, 8'h1F, 8'hE4, 8'h62}, pixel_valid = 1 at cycle t.
  - Required: rgb_out = 8'h1F and rgb_valid = 1 at t+2.
- All transparent:
  - Stimulus: every layer = 8'h62, valid = 1.
  - Required: rgb_out = 8'h00 (BG_COLOR).
  - Stimulus: valid = 0 with layer 0 = 8'hFF.
  - Required: rgb_out = 8'h00 and rgb_valid = 0.
- Collision report:
  - Stimulus: during frame N, one pixel with layer 0 = 8'hFF and layer 2 = 8'hE4, valid = 1.
  - Required: at the next frame_start + 1 cycle, collision_vec = 4'b0100 and collision_pulse is high for exactly 1 cycle.
- Cooldown (COOLDOWN_FRAMES = 3):
  - Stimulus: overlap with layer 1 in every frame.
  - Required: reported in frame 1, suppressed (collision_vec = 0, no pulse) for the next 3 reports, reported again on the 5th report.
- Edge timing and reset:
  - Stimulus: a hit pixel presented 1 cycle before frame_start.
  - Required: it is counted in the ending frame.
  - Stimulus: resetN asserted mid-frame after a hit.
  - Required: all outputs read 0 immediately; the next report shows no collision.
- Overlay:
  - Stimulus: with SPRITE_COLLISION_OVERLAY_EN defined, a hit pixel on layers 0 and 3.
  - Required: rgb_out = 8'hE0 at t+2.
  - Required (macro undefined): the same stimulus gives layer 0's colour.
